// File: rtl/alu_arbiter.sv
// alu_arbiter
// -----------
// Shares one externally instantiated, registered ALU between two requesters.
// Each requester offers operands and an opcode with a valid/ready handshake.
// One request is granted at a time (round-robin on contention), driven into
// the ALU for a single enabled cycle, and the ALU's registered result is
// returned on one response channel tagged with the requester id.
//
// Ports
//   clk                     system clock, all state on the rising edge
//   arst                    asynchronous active-high reset (also resets the ALU)
//   req0_valid/req1_valid   request present on port 0 / 1
//   req0_ready/req1_ready   request accepted this cycle (combinational, IDLE only)
//   req{0,1}_a, req{0,1}_b  operands, WIDTH bits
//   req{0,1}_op             opcode, OP_W bits
//   alu_a, alu_b, alu_op    registered ALU operands / opcode
//   alu_en                  ALU enable, one cycle per operation
//   alu_result              ALU registered result, 2*WIDTH bits
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester that issued the operation
//   rsp_data                captured ALU result
//   rsp_err                 opcode was outside 0..7
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [OP_W-1:0]      req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [OP_W-1:0]      req1_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OP_W-1:0]      alu_op,
  output logic                 alu_en,
  input  logic [2*WIDTH-1:0]   alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_err
);

  localparam int RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg;
  logic                winner_reg;
  logic                err_reg;
  logic [WIDTH-1:0]    alu_a_reg, alu_b_reg;
  logic [OP_W-1:0]     alu_op_reg;
  logic [RES_W-1:0]    rsp_data_reg;
  logic                rsp_id_reg;
  logic                rsp_err_reg;

  logic                any_valid;
  logic                win_sel;
  logic                accept;
  logic [1:0]          ready_vec;
  logic [WIDTH-1:0]    win_a, win_b;
  logic [OP_W-1:0]     win_op;
  logic                win_err;

  // Arbitration: a lone requester always wins; on contention the port that
  // did not win last time gets the grant.
  assign any_valid = req0_valid | req1_valid;
  assign win_sel   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;

  // Ready is held low while reset is asserted so every output reads zero
  // during reset, even though the IDLE state would otherwise allow a grant.
  assign accept = (state_reg == IDLE) && any_valid && !arst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = accept && (win_sel == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign win_a   = win_sel ? req1_a  : req0_a;
  assign win_b   = win_sel ? req1_b  : req0_b;
  assign win_op  = win_sel ? req1_op : req0_op;
  // Opcodes 8 and above are flagged but still sent through the ALU.
  assign win_err = ({1'b0, win_op} >= (OP_W + 1)'(8));

  // Next-state and decoded outputs.
  always_comb begin
    state_next = state_reg;
    alu_en     = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        alu_en     = 1'b1;
        state_next = CAPT;
      end
      CAPT: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      winner_reg     <= 1'b0;
      err_reg        <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Operands are loaded only on accept and otherwise hold; alu_en is
      // the sole qualifier the ALU looks at.
      if (accept) begin
        alu_a_reg      <= win_a;
        alu_b_reg      <= win_b;
        alu_op_reg     <= win_op;
        last_grant_reg <= win_sel;
        winner_reg     <= win_sel;
        err_reg        <= win_err;
      end
      // The ALU registered its result on the EXEC edge, so it is stable here.
      if (state_reg == CAPT) begin
        rsp_data_reg <= alu_result;
        rsp_id_reg   <= winner_reg;
        rsp_err_reg  <= err_reg;
      end
    end
  end

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_op   = alu_op_reg;
  assign rsp_data = rsp_data_reg;
  assign rsp_id   = rsp_id_reg;
  assign rsp_err  = rsp_err_reg;

endmodule
